ex_mem_regs: RTL
================

Name: ex_mem_regs

Overview:
Elastic EX/MEM pipeline register: captures execute-stage results (pc, ALU result, store data, destination register, control) and presents them to the MEM stage. Consumes what the ID/EX register produces once EX has evaluated it. Decouples EX from MEM stalls with a 2-entry skid buffer (main + skid), supports pipeline flush, and exports a forwarding tap for EX-stage bypass.

Parameters:
INSTR_WIDTH, 32, pc width
DATA_WIDTH, 64, ALU result / store data width
CONTROL_WIDTH, 16, MEM/WB control bundle width
REG_ADDR_WIDTH, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  EX presents a result
in_ready  out  1  register can accept (no skid entry held)
pc_in  in  INSTR_WIDTH  instruction pc
alu_in  in  DATA_WIDTH  ALU result / effective address
store_in  in  DATA_WIDTH  store data (val_b after forwarding)
rd_in  in  REG_ADDR_WIDTH  destination register
control_in  in  CONTROL_WIDTH  control bundle; bit 0 = reg_write
flush  in  1  discard all held and incoming entries
out_valid  out  1  main entry valid to MEM
out_ready  in  1  MEM accepts main entry
pc_out, alu_out, store_out, rd_out, control_out  out  as inputs  main-entry fields
fwd_valid  out  1  out_valid & control_out[0] & (rd_out != 0)
fwd_rd  out  REG_ADDR_WIDTH  = rd_out
fwd_data  out  DATA_WIDTH  = alu_out

Behaviour:
- Reset (reset==0, async): main_valid=0, skid_valid=0, all payload regs 0; outputs: out_valid=0, in_ready=1, fwd_valid=0, payload outputs 0.
- in_ready = ~skid_valid (registered state only; no combinational path from out_ready).
- Accept: acc = in_valid & in_ready. Drain: drn = out_valid & out_ready.
- Latency: accepted entry appears on outputs next cycle when main empty or draining; 1 cycle min.
- Main update per cycle (flush=0):
  - main empty or drn: if skid_valid, main<=skid, skid_valid<=0 (even if acc=0 — acc impossible while skid_valid); else if acc, main<=input; else main_valid<=0.
  - main full and ~drn: if acc, skid<=input, skid_valid<=1; main holds.
- Ordering strictly FIFO: skid entry always precedes any later input.
- Flush (synchronous, highest priority): next cycle main_valid=0, skid_valid=0; concurrent in_valid discarded; concurrent drn still counts as accepted by MEM that cycle. Payload regs may hold stale values; outputs valid-qualified.
- Simultaneous acc & drn with main full, skid empty: main<=input, no skid use.
- out payload and fwd_* stable while out_valid & ~out_ready.
- Reset asserted mid-transfer: entries lost, no partial state; in_ready=1 immediately (async).
- Width rules: all fields pass through unmodified; no sign extension.

Decomposition:
- Shared package pipeline_pkg: ex_mem_t packed struct {pc, alu, store, rd, control}, CTRL_REG_WRITE_BIT=0, default widths.
- One sub-module natural: skid_slot (payload reg + valid bit with load/clear), instanced twice (main, skid).

Test Plan:
- Reset low with in_valid=1 -> out_valid=0, in_ready=1, fwd_valid=0; after release, pc_in=0x100, alu_in=0x2A, out_ready=1 -> next cycle out_valid=1, pc_out=0x100, alu_out=0x2A.
- Streaming 4 entries back-to-back, out_ready=1 -> out sequence identical, 1-cycle latency, in_ready never drops.
- out_ready=0 while sending A,B -> A held in main, B in skid, in_ready=0; C held by EX; out_ready=1 -> outputs A,B,C in consecutive cycles, none lost/duplicated.
- flush=1 with main and skid full plus in_valid=1 (entry D) -> next cycle out_valid=0, in_ready=1; D never appears.
- rd_in=0, control_in[0]=1 -> fwd_valid=0; rd_in=7, control_in[0]=1, alu_in=0x55 -> fwd_valid=1, fwd_rd=7, fwd_data=0x55; control_in[0]=0 -> fwd_valid=0.
- Async reset asserted mid-cycle while skid full -> out_valid and skid cleared before next clk edge, in_ready=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and default widths for the EX/MEM stage boundary.
// Modules override the widths through their own parameters.
package pipeline_pkg;

  localparam int DEF_INSTR_WIDTH    = 32;
  localparam int DEF_DATA_WIDTH     = 64;
  localparam int DEF_CONTROL_WIDTH  = 16;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int CTRL_REG_WRITE_BIT = 0;

  typedef struct packed {
    logic [DEF_INSTR_WIDTH-1:0]    pc;
    logic [DEF_DATA_WIDTH-1:0]     alu;
    logic [DEF_DATA_WIDTH-1:0]     store;
    logic [DEF_REG_ADDR_WIDTH-1:0] rd;
    logic [DEF_CONTROL_WIDTH-1:0]  control;
  } ex_mem_t;

endpackage

// File: rtl/skid_slot.sv
// One storage slot of the elastic register: a payload register plus a valid bit.
// Clear beats load; the payload is left stale on clear because consumers qualify it with valid.
module skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/ex_mem_regs.sv
// Elastic EX/MEM pipeline register: a main slot facing MEM and a skid slot that
// absorbs one extra result while MEM stalls, plus a forwarding tap for EX bypass.
module ex_mem_regs
  import pipeline_pkg::*;
#(
  parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int CONTROL_WIDTH  = DEF_CONTROL_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INSTR_WIDTH-1:0]    pc_in,
  input  logic [DATA_WIDTH-1:0]     alu_in,
  input  logic [DATA_WIDTH-1:0]     store_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic [CONTROL_WIDTH-1:0]  control_in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_WIDTH-1:0]    pc_out,
  output logic [DATA_WIDTH-1:0]     alu_out,
  output logic [DATA_WIDTH-1:0]     store_out,
  output logic [REG_ADDR_WIDTH-1:0] rd_out,
  output logic [CONTROL_WIDTH-1:0]  control_out,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  localparam int W = INSTR_WIDTH + 2 * DATA_WIDTH + REG_ADDR_WIDTH + CONTROL_WIDTH;

  logic [W-1:0] in_payload;
  logic [W-1:0] main_d;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         main_valid;
  logic         skid_valid;
  logic         main_load;
  logic         main_clear;
  logic         skid_load;
  logic         skid_clear;
  logic         acc;
  logic         drn;

  assign in_payload = {pc_in, alu_in, store_in, rd_in, control_in};
  assign {pc_out, alu_out, store_out, rd_out, control_out} = main_q;

  // in_ready depends only on registered state, so no combinational path from out_ready
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign acc       = in_valid & in_ready;
  assign drn       = main_valid & out_ready;

  // The skid entry is always older than the input, so it wins the refill of main
  assign main_d = skid_valid ? skid_q : in_payload;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!main_valid || drn) begin
      if (skid_valid) begin
        main_load  = 1'b1;
        skid_clear = 1'b1;
      end else if (acc) begin
        main_load = 1'b1;
      end else begin
        main_clear = 1'b1;
      end
    end else if (acc) begin
      skid_load = 1'b1;
    end
  end

  skid_slot #(.W(W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  skid_slot #(.W(W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_payload),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign fwd_valid = main_valid & control_out[CTRL_REG_WRITE_BIT] & (rd_out != '0);
  assign fwd_rd    = rd_out;
  assign fwd_data  = alu_out;

endmodule
